// File: rtl/truth_table_sweep.sv
// truth_table_sweep
//
// Exhaustive sweep engine for an N_IN-input combinational function. When
// started, it walks every input vector 0 .. 2^N_IN-1 and holds each one for
// HOLD+1 cycles. On the last cycle of each vector it compares M_FUNC parallel
// implementations against a golden truth table (minterm mask). Every output
// is registered, so no combinational path runs from f_in to an output.
//
// Parameters
//   N_IN   : number of function inputs (sweep length 2^N_IN)
//   M_FUNC : number of implementations compared in parallel
//   HOLD   : settle cycles per vector before sampling (0..15)
//
// Ports
//   clk             in   single clock, rising edge
//   rst_n           in   synchronous active-low reset
//   start           in   sweep request, honoured only in IDLE
//   minterm_mask    in   golden truth table, bit k = expected output at vector k
//   f_in            in   outputs of the implementations, bit j = channel j
//   vec             out  input vector currently driven to the implementations
//   busy            out  sweep in progress
//   done            out  one-cycle pulse at the end of a sweep
//   pass            out  last completed sweep had no mismatches
//   err_count       out  number of vectors with at least one bad channel
//   first_err_vec   out  vector of the first mismatch
//   first_err_valid out  at least one mismatch recorded
//   fail_chan       out  sticky OR of the mismatching channels
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; results of the previous sweep are held
// APPLY  | vec is driven; hold counter runs 0..HOLD, compare at HOLD
// DONE   | one-cycle done pulse, vec back to 0, then IDLE

module truth_table_sweep #(
    parameter int N_IN   = 3,
    parameter int M_FUNC = 4,
    parameter int HOLD   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   minterm_mask,
    input  logic [M_FUNC-1:0]      f_in,
    output logic [N_IN-1:0]        vec,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [N_IN-1:0]        first_err_vec,
    output logic                   first_err_valid,
    output logic [M_FUNC-1:0]      fail_chan
);

    localparam int NUM_VEC = 1 << N_IN;

    localparam logic [3:0]      HOLD_CNT = 4'(HOLD);
    localparam logic [3:0]      CNT_ONE  = 4'd1;
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [NUM_VEC-1:0]   mask_q, mask_nx;
    logic [3:0]           cnt, cnt_nx;
    logic [N_IN-1:0]      vec_nx;
    logic                 busy_nx;
    logic                 done_nx;
    logic                 pass_nx;
    logic [N_IN:0]        err_nx;
    logic [N_IN-1:0]      fev_nx;
    logic                 fevv_nx;
    logic [M_FUNC-1:0]    fail_nx;
    logic [M_FUNC-1:0]    miss;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            mask_q          <= '0;
            cnt             <= '0;
            vec             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            fail_chan       <= '0;
        end else begin
            state           <= state_nx;
            mask_q          <= mask_nx;
            cnt             <= cnt_nx;
            vec             <= vec_nx;
            busy            <= busy_nx;
            done            <= done_nx;
            pass            <= pass_nx;
            err_count       <= err_nx;
            first_err_vec   <= fev_nx;
            first_err_valid <= fevv_nx;
            fail_chan       <= fail_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mask_nx  = mask_q;
        cnt_nx   = cnt;
        vec_nx   = vec;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        pass_nx  = pass;
        err_nx   = err_count;
        fev_nx   = first_err_vec;
        fevv_nx  = first_err_valid;
        fail_nx  = fail_chan;
        // Every channel should equal the golden bit for the current vector.
        miss     = f_in ^ {M_FUNC{mask_q[vec]}};

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_APPLY;
                    mask_nx  = minterm_mask;
                    cnt_nx   = '0;
                    vec_nx   = '0;
                    busy_nx  = 1'b1;
                    pass_nx  = 1'b0;
                    err_nx   = '0;
                    fev_nx   = '0;
                    fevv_nx  = 1'b0;
                    fail_nx  = '0;
                end
            end

            S_APPLY: begin
                busy_nx = 1'b1;
                if (cnt == HOLD_CNT) begin
                    if (miss != '0) begin
                        err_nx  = err_count + ERR_ONE;
                        fail_nx = fail_chan | miss;
                        if (!first_err_valid) begin
                            fev_nx  = vec;
                            fevv_nx = 1'b1;
                        end
                    end
                    if (vec == VEC_LAST) begin
                        // pass is taken from the final count so it is
                        // already valid in the cycle done is high.
                        state_nx = S_DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        pass_nx  = (err_nx == '0);
                        vec_nx   = '0;
                        cnt_nx   = '0;
                    end else begin
                        vec_nx = vec + VEC_ONE;
                        cnt_nx = '0;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep with N_IN=3, M_FUNC=4, HOLD=1 and the
// majority function as golden table. Four channels implement majority in
// different forms (SOP, POS, factored, case); fault_mode corrupts them.
// Stimulus pushes the expected outcome of each sweep into a queue; a monitor
// on the falling edge tracks busy/vec and pops/compares when done pulses.

module tb_truth_table_sweep;

    localparam int N_IN   = 3;
    localparam int M_FUNC = 4;
    localparam int HOLD   = 1;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [7:0]            minterm_mask;
    logic [M_FUNC-1:0]     f_in;
    logic [N_IN-1:0]       vec;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [N_IN:0]         err_count;
    logic [N_IN-1:0]       first_err_vec;
    logic                  first_err_valid;
    logic [M_FUNC-1:0]     fail_chan;

    truth_table_sweep #(.N_IN(N_IN), .M_FUNC(M_FUNC), .HOLD(HOLD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .minterm_mask    (minterm_mask),
        .f_in            (f_in),
        .vec             (vec),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid),
        .fail_chan       (fail_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         bs;
        int         dc;
        logic [3:0] err;
        logic [2:0] fev;
        logic       fevv;
        logic [3:0] fail;
        logic       pass;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fault_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Four independent majority implementations plus fault injection.
    function automatic logic [3:0] model(input logic [2:0] v, input int mode);
        logic       a, b, c;
        logic [3:0] f;
        a = v[2];
        b = v[1];
        c = v[0];
        f[0] = (a & b) | (a & c) | (b & c);
        f[1] = (a | b) & (a | c) & (b | c);
        f[2] = (a & (b | c)) | (b & c);
        case (v)
            3'd3, 3'd5, 3'd6, 3'd7: f[3] = 1'b1;
            default:                f[3] = 1'b0;
        endcase
        if (mode == 1 && v == 3'd5) f[2] = ~f[2];
        if (mode == 2) f = ~f;
        return f;
    endfunction

    always_comb f_in = model(vec, fault_mode);

    // Monitor
    bit   in_busy = 0;
    int   bstart  = 0;
    int   blen    = 0;
    int   vbad    = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_busy = 0;
        end else begin
            if (busy && !in_busy) begin
                in_busy = 1;
                bstart  = cyc;
                blen    = 0;
                vbad    = 0;
                chk("clear_err_count", err_count, 0);
                chk("clear_fail_chan", fail_chan, 0);
                chk("clear_first_err_valid", first_err_valid, 0);
                chk("clear_pass", pass, 0);
            end
            if (busy) begin
                blen++;
                if (vec !== 3'((cyc - bstart) / (HOLD + 1))) vbad++;
            end else begin
                in_busy = 0;
            end
            if (done) begin
                chk("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("busy_start_cycle", bstart, e.bs);
                    chk("done_cycle", cyc, e.dc);
                    chk("busy_length", blen, 16);
                    chk("vec_sequence_errors", vbad, 0);
                    chk("busy_low_at_done", busy, 0);
                    chk("err_count", err_count, e.err);
                    chk("first_err_valid", first_err_valid, e.fevv);
                    if (e.fevv) chk("first_err_vec", first_err_vec, e.fev);
                    chk("fail_chan", fail_chan, e.fail);
                    chk("pass", pass, e.pass);
                end
            end
        end
    end

    task automatic push_exp(input int bs, input logic [3:0] err, input logic [2:0] fev,
                            input logic fevv, input logic [3:0] fail, input logic ps);
        exp_t x;
        x.bs   = bs;
        x.dc   = bs + 16;
        x.err  = err;
        x.fev  = fev;
        x.fevv = fevv;
        x.fail = fail;
        x.pass = ps;
        exp_q.push_back(x);
    endtask

    // Called at a falling edge: pulse start for one cycle and return the
    // cycle index at which the DUT samples it.
    task automatic pulse_start(output int s);
        s = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, done, 1);
    endtask

    task automatic wait_vec(input logic [2:0] v);
        int n = 0;
        while (vec !== v && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_vec_reached", vec, v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vec"}, vec, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_err_vec"}, first_err_vec, 0);
        chk({tag, "_first_err_valid"}, first_err_valid, 0);
        chk({tag, "_fail_chan"}, fail_chan, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst_n        = 1'b0;
        start        = 1'b0;
        minterm_mask = 8'b1110_1000;
        fault_mode   = 0;

        // 1. reset
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // 2. clean sweep
        fault_mode = 0;
        push_exp(cyc + 1, 4'd0, 3'd0, 1'b0, 4'b0000, 1'b1);
        pulse_start(s);
        wait_done("clean");
        idle(3);

        // 3. channel 2 inverted at vec 5
        fault_mode = 1;
        push_exp(cyc + 1, 4'd1, 3'd5, 1'b1, 4'b0100, 1'b0);
        pulse_start(s);
        wait_done("single");
        idle(3);

        // 4. all channels inverted everywhere
        fault_mode = 2;
        push_exp(cyc + 1, 4'd8, 3'd0, 1'b1, 4'b1111, 1'b0);
        pulse_start(s);
        wait_done("total");
        idle(4);
        chk("results_held_err_count", err_count, 8);
        chk("results_held_fail_chan", fail_chan, 4'hF);

        // 5. start during a sweep, then held through done
        fault_mode = 2;
        push_exp(cyc + 1, 4'd8, 3'd0, 1'b1, 4'b1111, 1'b0);
        pulse_start(s);
        wait_vec(3'd4);
        start = 1'b1;
        push_exp(s + 18, 4'd0, 3'd0, 1'b0, 4'b0000, 1'b1);
        wait_done("overlap_first");
        begin
            int n = 0;
            @(negedge clk);
            while (!busy && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("overlap_restart_busy", busy, 1);
        end
        start      = 1'b0;
        fault_mode = 0;
        wait_done("overlap_second");
        idle(3);

        // 6. reset mid-sweep
        fault_mode = 2;
        push_exp(cyc + 1, 4'd0, 3'd0, 1'b0, 4'b0000, 1'b0);
        pulse_start(s);
        wait_vec(3'd3);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk_reset_outputs("midreset");
        rst_n      = 1'b1;
        fault_mode = 0;
        idle(25);
        push_exp(cyc + 1, 4'd0, 3'd0, 1'b0, 4'b0000, 1'b1);
        pulse_start(s);
        wait_done("after_reset");
        idle(5);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
